udp_sample_unpacker: RTL and testbench
======================================

// Module: udp_sample_unpacker
// PURPOSE
// - Receive-side counterpart of the ADC capture buffer/Ethernet transmit path.
// - Consumes the 8-bit payload byte stream of one UDP packet: a block of channel-1 bytes,
//   then a block of channel-2 bytes.
// - Reassembles the bytes into two 16-bit sample streams.
// - Checks frame length and flags errors. Used in loopback benches and the host-side FPGA model.
// - Sits in the clk_125m domain directly behind the UDP RX payload extractor.
// PARAMETERS
// - SAMPLES_PER_CH  512  16-bit samples per channel per frame (2*SAMPLES_PER_CH bytes per channel)
// - MSB_FIRST       1    1: high byte of each sample arrives first; 0: low byte first
// PORTS
// - clk          in   1   clk_125m; all logic is on the rising edge
// - rstn         in   1   synchronous, active-low reset
// - rx_valid     in   1   rx_data is valid this cycle; gaps (rx_valid=0) are allowed inside a frame
// - rx_data      in   8   payload byte
// - rx_last      in   1   qualifies the final byte of the frame; ignored when rx_valid=0
// - ch1_data     out  16  reassembled channel-1 sample
// - ch1_valid    out  1   one-cycle strobe, ch1_data valid
// - ch2_data     out  16  reassembled channel-2 sample
// - ch2_valid    out  1   one-cycle strobe, ch2_data valid
// - frame_done   out  1   one-cycle strobe: frame ended with the exact length
// - frame_err    out  1   one-cycle strobe: frame ended short or long
// - frame_cnt    out  16  count of good frames, wraps at 0xFFFF->0
// BEHAVIOUR
// - Reset (rstn=0 at clk edge): every output is 0; FSM goes to CH1; byte phase and sample
//   counter are cleared.
// - Reset mid-frame discards the partial sample and the partial frame. No strobe is issued.
// - FSM states {CH1, CH2, DISCARD}, encoded as enum rx_state_t:
//   - CH1: accepted bytes build channel-1 samples. After SAMPLES_PER_CH samples, go to CH2.
//   - CH2: same for channel 2. After SAMPLES_PER_CH samples with rx_last on the final byte:
//     pulse frame_done, increment frame_cnt, return to CH1.
//   - CH2, final byte without rx_last: go to DISCARD. No strobe yet.
//   - DISCARD: drop bytes until rx_last, then pulse frame_err and return to CH1.
// - A byte is accepted only when rx_valid=1. The byte phase toggles on each accepted byte.
//   A sample completes on every second accepted byte.
// - Sample assembly:
//   - MSB_FIRST=1: first byte goes to [15:8], second byte to [7:0].
//   - MSB_FIRST=0: the reverse.
// - Latency: chN_valid is asserted in the cycle after the second byte of the sample is
//   accepted, with chN_data registered.
// - Only one of ch1_valid/ch2_valid is asserted per cycle.
// - Early rx_last (in CH1, or in CH2 before the final byte):
//   - The completing sample, if any, is still emitted.
//   - Any odd trailing byte is dropped.
//   - frame_err pulses in the cycle after the rx_last byte; FSM returns to CH1.
// - frame_done and frame_err are registered one cycle after the accepting edge.
//   They are never asserted together.
// - chN_data holds its last value between strobes.
// - Sample counter width is $clog2(SAMPLES_PER_CH)+1. It clears on each channel switch
//   and on each frame end.
// - Back-to-back frames: a byte arriving the cycle after rx_last belongs to the new frame
//   and is accepted in CH1 with no bubble.
// STRUCTURE
// - buffer_pkg: rx_state_t enum; BYTES_PER_SAMPLE=2 constant.
//   (Shared with the write/read controllers.)
// - Sub-module sample_assembler (clk, rstn, clr, byte_valid, byte_in -> sample, sample_valid).
//   - One instance; clr is driven on frame end.
//   - Its sample_valid is steered to ch1_valid/ch2_valid by the FSM.
// TESTING
// - Use SAMPLES_PER_CH=4, MSB_FIRST=1.
// 1. Nominal frame: bytes 00..0F contiguous, rx_last on 0F.
//    -> ch1 = 0001,0203,0405,0607; ch2 = 0809,0A0B,0C0D,0E0F;
//       frame_done one cycle after 0F; frame_cnt=1.
// 2. Same frame with rx_valid=0 inserted every other cycle
//    -> identical samples; total cycle count scales with the gaps.
// 3. Short frame: rx_last on byte 0x06 (7 bytes)
//    -> ch1 = 0001,0203,0405; byte 06 dropped; frame_err pulses; frame_cnt unchanged;
//       the next good frame is decoded correctly.
// 4. Long frame: 20 bytes, rx_last on the 20th
//    -> all 8 samples emitted; no done after byte 16; frame_err one cycle after byte 20;
//       frame_cnt unchanged.
// 5. rstn=0 for one cycle after byte 0x05
//    -> no strobes; all outputs 0; a fresh 16-byte frame decodes with ch1 starting
//       at the new first byte pair.
// 6. Two frames back-to-back, no gap; MSB_FIRST=0 variant
//    -> ch1[0]=0100 in each frame; two frame_done pulses; frame_cnt=2.

Source files
------------

// File: rtl/udp_sample_unpacker_pkg.sv
// Shared types for the UDP sample receive path: frame FSM states and sample geometry.
package udp_sample_unpacker_pkg;

    localparam int BYTES_PER_SAMPLE = 2;

    typedef enum logic [1:0] {
        CH1     = 2'd0,
        CH2     = 2'd1,
        DISCARD = 2'd2
    } rx_state_t;

endpackage

// File: rtl/udp_sample_unpacker_if.sv
// Payload byte stream in, two reassembled sample streams and frame status out.
interface udp_sample_unpacker_if;

    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_last;
    logic [15:0] ch1_data;
    logic        ch1_valid;
    logic [15:0] ch2_data;
    logic        ch2_valid;
    logic        frame_done;
    logic        frame_err;
    logic [15:0] frame_cnt;

    modport master (
        output rx_valid, rx_data, rx_last,
        input  ch1_data, ch1_valid, ch2_data, ch2_valid, frame_done, frame_err, frame_cnt
    );

    modport slave (
        input  rx_valid, rx_data, rx_last,
        output ch1_data, ch1_valid, ch2_data, ch2_valid, frame_done, frame_err, frame_cnt
    );

endinterface

// File: rtl/udp_sample_unpacker_assembler.sv
// Pairs accepted bytes into 16-bit samples; the completed sample is presented combinationally
// with the second byte so the caller can register it together with its channel decision.
module sample_assembler
    import udp_sample_unpacker_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [15:0] sample,
    output logic        sample_valid
);

    localparam int PW = $clog2(BYTES_PER_SAMPLE);

    logic [PW-1:0] r_phase;
    logic [7:0]    r_first;

    assign sample_valid = byte_valid && (r_phase == PW'(BYTES_PER_SAMPLE - 1));
    assign sample       = MSB_FIRST ? {r_first, byte_in} : {byte_in, r_first};

    // clr still lets a completing sample out this cycle but drops a lone trailing byte
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_phase <= '0;
            r_first <= '0;
        end else begin
            if (byte_valid && r_phase == '0)
                r_first <= byte_in;
            if (clr)
                r_phase <= '0;
            else if (byte_valid)
                r_phase <= r_phase + 1'b1;
        end
    end

endmodule

// File: rtl/udp_sample_unpacker.sv
// Splits one UDP payload into channel-1 and channel-2 sample streams and checks frame length.
module udp_sample_unpacker
    import udp_sample_unpacker_pkg::*;
#(
    parameter int SAMPLES_PER_CH = 512,
    parameter bit MSB_FIRST      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstn,
    udp_sample_unpacker_if.slave  bus
);

    localparam int             CW       = $clog2(SAMPLES_PER_CH) + 1;
    localparam logic [CW-1:0]  LAST_IDX = CW'(SAMPLES_PER_CH - 1);

    rx_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic [15:0]  r_ch1_data, r_ch2_data, r_frame_cnt;
    logic         r_ch1_valid, r_ch2_valid, r_frame_done, r_frame_err;

    logic         w_asm_valid, w_end, w_smp, w_last_smp;
    logic [15:0]  w_sample;

    assign w_asm_valid = bus.rx_valid && (r_state != DISCARD);
    assign w_end       = bus.rx_valid && bus.rx_last;
    assign w_last_smp  = w_smp && (r_cnt == LAST_IDX);

    sample_assembler #(.MSB_FIRST(MSB_FIRST)) u_asm (
        .clk          (clk),
        .rstn         (rstn),
        .clr          (w_end),
        .byte_valid   (w_asm_valid),
        .byte_in      (bus.rx_data),
        .sample       (w_sample),
        .sample_valid (w_smp)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= CH1;
            r_cnt        <= '0;
            r_ch1_data   <= '0;
            r_ch2_data   <= '0;
            r_ch1_valid  <= 1'b0;
            r_ch2_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_ch1_valid  <= 1'b0;
            r_ch2_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                CH1: begin
                    if (w_smp) begin
                        r_ch1_data  <= w_sample;
                        r_ch1_valid <= 1'b1;
                        r_cnt       <= r_cnt + 1'b1;
                    end
                    if (w_end) begin
                        r_frame_err <= 1'b1;
                        r_cnt       <= '0;
                    end else if (w_last_smp) begin
                        r_cnt   <= '0;
                        r_state <= CH2;
                    end
                end
                CH2: begin
                    if (w_smp) begin
                        r_ch2_data  <= w_sample;
                        r_ch2_valid <= 1'b1;
                        r_cnt       <= r_cnt + 1'b1;
                    end
                    // Exact length only if rx_last lands on the byte closing the last sample
                    if (w_last_smp) begin
                        r_cnt <= '0;
                        if (bus.rx_last) begin
                            r_frame_done <= 1'b1;
                            r_frame_cnt  <= r_frame_cnt + 16'd1;
                            r_state      <= CH1;
                        end else begin
                            r_state <= DISCARD;
                        end
                    end else if (w_end) begin
                        r_frame_err <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= CH1;
                    end
                end
                DISCARD: begin
                    if (w_end) begin
                        r_frame_err <= 1'b1;
                        r_state     <= CH1;
                    end
                end
                default: r_state <= CH1;
            endcase
        end
    end

    assign bus.ch1_data   = r_ch1_data;
    assign bus.ch1_valid  = r_ch1_valid;
    assign bus.ch2_data   = r_ch2_data;
    assign bus.ch2_valid  = r_ch2_valid;
    assign bus.frame_done = r_frame_done;
    assign bus.frame_err  = r_frame_err;
    assign bus.frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_udp_sample_unpacker.sv
// Directed bench: one MSB-first and one LSB-first unpacker fed the same byte stream.
module tb_udp_sample_unpacker;

    logic       clk;
    logic       rstn;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_last;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int c0;
    int na_done, na_err, nb_done, nb_err;
    logic [15:0] qa1[$], qa2[$], qb1[$], qb2[$];

    udp_sample_unpacker_if bus_a ();
    udp_sample_unpacker_if bus_b ();

    assign bus_a.rx_valid = rx_valid;
    assign bus_a.rx_data  = rx_data;
    assign bus_a.rx_last  = rx_last;
    assign bus_b.rx_valid = rx_valid;
    assign bus_b.rx_data  = rx_data;
    assign bus_b.rx_last  = rx_last;

    udp_sample_unpacker #(.SAMPLES_PER_CH(4), .MSB_FIRST(1'b1)) u_a (
        .clk (clk), .rstn (rstn), .bus (bus_a)
    );
    udp_sample_unpacker #(.SAMPLES_PER_CH(4), .MSB_FIRST(1'b0)) u_b (
        .clk (clk), .rstn (rstn), .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs are stable at the falling edge; collect strobes and samples there.
    always @(negedge clk) begin
        cyc++;
        if (bus_a.ch1_valid) qa1.push_back(bus_a.ch1_data);
        if (bus_a.ch2_valid) qa2.push_back(bus_a.ch2_data);
        if (bus_b.ch1_valid) qb1.push_back(bus_b.ch1_data);
        if (bus_b.ch2_valid) qb2.push_back(bus_b.ch2_data);
        if (bus_a.frame_done) na_done++;
        if (bus_a.frame_err)  na_err++;
        if (bus_b.frame_done) nb_done++;
        if (bus_b.frame_err)  nb_err++;
        if (bus_a.ch1_valid || bus_a.ch2_valid)
            chk("a ch exclusive", {31'd0, bus_a.ch1_valid & bus_a.ch2_valid}, 32'd0);
        if (bus_a.frame_done || bus_a.frame_err)
            chk("a done/err exclusive", {31'd0, bus_a.frame_done & bus_a.frame_err}, 32'd0);
    end

    task automatic step(input bit v, input logic [7:0] d, input bit l);
        @(negedge clk);
        #1;
        rx_valid = v;
        rx_data  = d;
        rx_last  = l;
    endtask

    task automatic send_frame(input int base, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 8'(base + i), i == n - 1);
            if (gaps && i != n - 1) step(1'b0, 8'h00, 1'b0);
        end
    endtask

    task automatic clear_mon();
        qa1.delete(); qa2.delete(); qb1.delete(); qb2.delete();
        na_done = 0; na_err = 0; nb_done = 0; nb_err = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rstn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_last = 1'b0;
        @(negedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Sample i is built from bytes base+2i and base+2i+1.
    task automatic chk_samples(input string tag, input logic [15:0] q[$], input int base,
                               input int n, input bit msb);
        logic [7:0] b0, b1;
        chk({tag, " count"}, q.size(), n);
        for (int i = 0; i < n && i < q.size(); i++) begin
            b0 = 8'(base + 2 * i);
            b1 = 8'(base + 2 * i + 1);
            chk($sformatf("%s[%0d]", tag, i), q[i], msb ? {b0, b1} : {b1, b0});
        end
    endtask

    initial begin
        rstn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_last = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);
        #1;
        chk("rst ch1_data", bus_a.ch1_data, 16'h0);
        chk("rst ch2_data", bus_a.ch2_data, 16'h0);
        chk("rst valids", {bus_a.ch1_valid, bus_a.ch2_valid, bus_a.frame_done, bus_a.frame_err}, 4'h0);
        chk("rst frame_cnt", bus_a.frame_cnt, 16'h0);
        rstn = 1'b1;

        // 1: nominal contiguous frame
        clear_mon();
        c0 = cyc;
        send_frame(0, 16, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("t1 done", bus_a.frame_done, 1'b1);
        chk("t1 cycles", cyc - c0, 17);
        chk("t1 frame_cnt", bus_a.frame_cnt, 16'd1);
        chk("t1 err", na_err, 0);
        chk_samples("t1 ch1", qa1, 0, 4, 1'b1);
        chk_samples("t1 ch2", qa2, 8, 4, 1'b1);

        // 2: idle cycle between every byte
        clear_mon();
        c0 = cyc;
        send_frame(0, 16, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        chk("t2 done", bus_a.frame_done, 1'b1);
        chk("t2 cycles", cyc - c0, 32);
        chk("t2 frame_cnt", bus_a.frame_cnt, 16'd2);
        chk_samples("t2 ch1", qa1, 0, 4, 1'b1);
        chk_samples("t2 ch2", qa2, 8, 4, 1'b1);

        // 3: short frame, then a good one
        clear_mon();
        send_frame(0, 7, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("t3 err", bus_a.frame_err, 1'b1);
        chk("t3 done cnt", na_done, 0);
        chk("t3 frame_cnt", bus_a.frame_cnt, 16'd2);
        chk_samples("t3 ch1", qa1, 0, 3, 1'b1);
        chk("t3 ch2 count", qa2.size(), 0);
        clear_mon();
        send_frame(0, 16, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("t3b done", bus_a.frame_done, 1'b1);
        chk("t3b frame_cnt", bus_a.frame_cnt, 16'd3);
        chk_samples("t3b ch1", qa1, 0, 4, 1'b1);
        chk_samples("t3b ch2", qa2, 8, 4, 1'b1);

        // 4: long frame, 20 bytes
        clear_mon();
        send_frame(0, 20, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("t4 err", bus_a.frame_err, 1'b1);
        chk("t4 err cnt", na_err, 1);
        chk("t4 done cnt", na_done, 0);
        chk("t4 frame_cnt", bus_a.frame_cnt, 16'd3);
        chk_samples("t4 ch1", qa1, 0, 4, 1'b1);
        chk_samples("t4 ch2", qa2, 8, 4, 1'b1);

        // 5: reset mid-frame, then a fresh frame starting at 0x10
        for (int i = 0; i < 6; i++) step(1'b1, 8'(i), 1'b0);
        do_reset();
        chk("t5 ch1_data", bus_a.ch1_data, 16'h0);
        chk("t5 ch2_data", bus_a.ch2_data, 16'h0);
        chk("t5 strobes", {bus_a.ch1_valid, bus_a.ch2_valid, bus_a.frame_done, bus_a.frame_err}, 4'h0);
        chk("t5 frame_cnt", bus_a.frame_cnt, 16'h0);
        clear_mon();
        repeat (3) step(1'b0, 8'h00, 1'b0);
        chk("t5 quiet", qa1.size() + qa2.size() + na_done + na_err, 0);
        send_frame(16, 16, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("t5 done", bus_a.frame_done, 1'b1);
        chk("t5 frame_cnt new", bus_a.frame_cnt, 16'd1);
        chk_samples("t5 ch1", qa1, 16, 4, 1'b1);
        chk_samples("t5 ch2", qa2, 24, 4, 1'b1);

        // 6: two frames back-to-back, LSB-first instance checked too
        do_reset();
        clear_mon();
        send_frame(0, 16, 1'b0);
        send_frame(0, 16, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("t6 a done cnt", na_done, 2);
        chk("t6 b done cnt", nb_done, 2);
        chk("t6 a frame_cnt", bus_a.frame_cnt, 16'd2);
        chk("t6 b frame_cnt", bus_b.frame_cnt, 16'd2);
        chk("t6 b err cnt", nb_err, 0);
        chk("t6 b ch1 count", qb1.size(), 8);
        chk("t6 b ch1[0]", qb1[0], 16'h0100);
        chk("t6 b ch1[4]", qb1[4], 16'h0100);
        chk("t6 b ch1[3]", qb1[3], 16'h0706);
        chk("t6 b ch2[3]", qb2[3], 16'h0F0E);
        chk("t6 a ch1[4]", qa1[4], 16'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
